// File: rtl/decode_issue.sv
// Decode holding register and operand issue stage between fetch and execute.
// Selects forwarded operands, holds on load-use stalls, honours backpressure and flush.
module decode_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fe_valid,
  input  logic [31:0]      fe_insn,
  input  logic [XLEN-1:0]  fe_pc,
  output logic             fe_ready,
  output logic [4:0]       de_rs1,
  output logic [4:0]       de_rs2,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  input  logic [1:0]       forward_rs1,
  input  logic [1:0]       forward_rs2,
  input  logic             load_stall,
  input  logic [XLEN-1:0]  ex_fwd_data,
  input  logic [XLEN-1:0]  mem_fwd_data,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_pc,
  output logic [31:0]      ex_insn,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    NOT_FORWARDING = 2'b00,
    FORWARDING_EX  = 2'b01,
    FORWARDING_MEM = 2'b10
  } fwd_sel_e;

  logic             d_valid_q, d_valid_d;
  logic [31:0]      d_insn_q, d_insn_d;
  logic [XLEN-1:0]  d_pc_q, d_pc_d;
  logic             ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  logic [31:0]      ex_insn_q, ex_insn_d;
  logic [XLEN-1:0]  ex_op1_q, ex_op1_d;
  logic [XLEN-1:0]  ex_op2_q, ex_op2_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic             issue;
  logic             stall_cycle;
  logic [XLEN-1:0]  op1_sel, op2_sel;

  // Unused code 2'b11 falls back to the register file.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] ex,
    input logic [XLEN-1:0] mem
  );
    case (sel)
      FORWARDING_EX:  sel_operand = ex;
      FORWARDING_MEM: sel_operand = mem;
      default:        sel_operand = rf;
    endcase
  endfunction

  always_comb begin
    de_rs1      = d_insn_q[19:15];
    de_rs2      = d_insn_q[24:20];
    op1_sel     = sel_operand(forward_rs1, rf_rdata1, ex_fwd_data, mem_fwd_data);
    op2_sel     = sel_operand(forward_rs2, rf_rdata2, ex_fwd_data, mem_fwd_data);
    issue       = d_valid_q & ~load_stall & ex_ready & ~flush;
    stall_cycle = d_valid_q & load_stall & ~flush;
    fe_ready    = ~d_valid_q | issue;
  end

  always_comb begin
    d_valid_d = d_valid_q;
    d_insn_d  = d_insn_q;
    d_pc_d    = d_pc_q;
    if (flush) begin
      d_valid_d = 1'b0;
    end else if (fe_valid && fe_ready) begin
      d_valid_d = 1'b1;
      d_insn_d  = fe_insn;
      d_pc_d    = fe_pc;
    end else if (issue) begin
      d_valid_d = 1'b0;
    end
  end

  // Data fields move only on a real issue; bubbles and backpressure leave them as-is.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_insn_d  = ex_insn_q;
    ex_op1_d   = ex_op1_q;
    ex_op2_d   = ex_op2_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (ex_ready) begin
      ex_valid_d = issue;
      if (issue) begin
        ex_pc_d   = d_pc_q;
        ex_insn_d = d_insn_q;
        ex_op1_d  = op1_sel;
        ex_op2_d  = op2_sel;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q + CNT_W'(stall_cycle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_valid_q     <= 1'b0;
      d_insn_q      <= '0;
      d_pc_q        <= '0;
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_insn_q     <= '0;
      ex_op1_q      <= '0;
      ex_op2_q      <= '0;
      stall_count_q <= '0;
    end else begin
      d_valid_q     <= d_valid_d;
      d_insn_q      <= d_insn_d;
      d_pc_q        <= d_pc_d;
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_insn_q     <= ex_insn_d;
      ex_op1_q      <= ex_op1_d;
      ex_op2_q      <= ex_op2_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_valid_o  = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_insn     = ex_insn_q;
  assign ex_op1      = ex_op1_q;
  assign ex_op2      = ex_op2_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: expected issues queued at stimulus time,
// checked when execute consumes them; a narrow-counter instance checks wrap.
module tb_decode_issue;

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] NOF = 2'b00, FEX = 2'b01, FMEM = 2'b10;

  logic clk = 1'b0;
  logic reset, fe_valid, load_stall, ex_ready, flush;
  logic [31:0] fe_insn;
  logic [XLEN-1:0] fe_pc, rf_rdata1, rf_rdata2, ex_fwd_data, mem_fwd_data;
  logic [1:0] forward_rs1, forward_rs2;

  logic fe_ready, ex_valid_o;
  logic [4:0] de_rs1, de_rs2;
  logic [XLEN-1:0] ex_pc, ex_op1, ex_op2;
  logic [31:0] ex_insn, stall_count;

  logic n_fe_ready, n_ex_valid;
  logic [4:0] n_rs1, n_rs2;
  logic [XLEN-1:0] n_pc, n_op1, n_op2;
  logic [31:0] n_insn;
  logic [2:0] n_stall_count;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } issue_t;

  issue_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  decode_issue #(.XLEN(XLEN), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .fe_valid(fe_valid), .fe_insn(fe_insn), .fe_pc(fe_pc),
    .fe_ready(fe_ready), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .forward_rs1(forward_rs1), .forward_rs2(forward_rs2), .load_stall(load_stall),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
    .ex_ready(ex_ready), .flush(flush), .ex_valid_o(ex_valid_o), .ex_pc(ex_pc),
    .ex_insn(ex_insn), .ex_op1(ex_op1), .ex_op2(ex_op2), .stall_count(stall_count)
  );

  decode_issue #(.XLEN(XLEN), .CNT_W(3)) dut_narrow (
    .clk(clk), .reset(reset), .fe_valid(fe_valid), .fe_insn(fe_insn), .fe_pc(fe_pc),
    .fe_ready(n_fe_ready), .de_rs1(n_rs1), .de_rs2(n_rs2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .forward_rs1(forward_rs1), .forward_rs2(forward_rs2), .load_stall(load_stall),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
    .ex_ready(ex_ready), .flush(flush), .ex_valid_o(n_ex_valid), .ex_pc(n_pc),
    .ex_insn(n_insn), .ex_op1(n_op1), .ex_op2(n_op2), .stall_count(n_stall_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    mk_r = {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic [XLEN-1:0] pc, input logic [31:0] insn,
                              input logic [XLEN-1:0] op1, input logic [XLEN-1:0] op2);
    issue_t e;
    e.pc = pc; e.insn = insn; e.op1 = op1; e.op2 = op2;
    exp_q.push_back(e);
  endtask

  // Execute consumes an entry on any edge where it is valid and ready, unless killed.
  always @(negedge clk) begin
    if (!reset && !flush && ex_valid_o && ex_ready) begin
      check_eq("sb_unexpected_issue", 64'(exp_q.size() == 0), 64'd0);
      if (exp_q.size() != 0) begin
        issue_t e;
        e = exp_q.pop_front();
        check_eq("sb_pc",   64'(ex_pc),   64'(e.pc));
        check_eq("sb_insn", 64'(ex_insn), 64'(e.insn));
        check_eq("sb_op1",  64'(ex_op1),  64'(e.op1));
        check_eq("sb_op2",  64'(ex_op2),  64'(e.op2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fe_valid = 1'b0; fe_insn = '0; fe_pc = '0;
    rf_rdata1 = '0; rf_rdata2 = '0; forward_rs1 = NOF; forward_rs2 = NOF;
    load_stall = 1'b0; ex_fwd_data = '0; mem_fwd_data = '0; ex_ready = 1'b1; flush = 1'b0;
    step(); step();
    check_eq("rst_ex_valid", 64'(ex_valid_o), 64'd0);
    check_eq("rst_ex_pc", 64'(ex_pc), 64'd0);
    check_eq("rst_ex_op1", 64'(ex_op1), 64'd0);
    check_eq("rst_stall_count", 64'(stall_count), 64'd0);
    check_eq("rst_fe_ready", 64'(fe_ready), 64'd1);
    reset = 1'b0;

    // Plain issue
    fe_valid = 1'b1; fe_insn = mk_r(3, 1, 2); fe_pc = 32'h100;
    rf_rdata1 = 5; rf_rdata2 = 7;
    expect_issue(32'h100, mk_r(3, 1, 2), 5, 7);
    step();
    fe_valid = 1'b0;
    #1;
    check_eq("t1_de_rs1", 64'(de_rs1), 64'd1);
    check_eq("t1_de_rs2", 64'(de_rs2), 64'd2);
    check_eq("t1_not_yet_valid", 64'(ex_valid_o), 64'd0);
    step();
    check_eq("t1_ex_valid", 64'(ex_valid_o), 64'd1);
    check_eq("t1_ex_op1", 64'(ex_op1), 64'd5);

    // Forwarding, back-to-back
    fe_valid = 1'b1; fe_insn = mk_r(4, 3, 1); fe_pc = 32'h104;
    expect_issue(32'h104, mk_r(4, 3, 1), 32'hAA, 32'h55);
    step();
    forward_rs1 = FEX; ex_fwd_data = 32'hAA; forward_rs2 = FMEM; mem_fwd_data = 32'h55;
    fe_insn = mk_r(5, 6, 7); fe_pc = 32'h108;
    expect_issue(32'h108, mk_r(5, 6, 7), 3, 9);
    #1;
    check_eq("t2_fe_ready_b2b", 64'(fe_ready), 64'd1);
    step();
    fe_valid = 1'b0;
    forward_rs1 = 2'b11; rf_rdata1 = 3; forward_rs2 = NOF; rf_rdata2 = 9;
    step();
    check_eq("t2_ex_pc", 64'(ex_pc), 64'h108);

    // Load-use stall, next instruction presented but blocked
    forward_rs1 = NOF;
    fe_valid = 1'b1; fe_insn = mk_r(8, 5, 6); fe_pc = 32'h10C;
    step();
    fe_insn = mk_r(9, 10, 11); fe_pc = 32'h110;
    load_stall = 1'b1; rf_rdata1 = 11; rf_rdata2 = 12;
    #1;
    check_eq("t3_fe_ready_stall", 64'(fe_ready), 64'd0);
    step();
    check_eq("t3_bubble1", 64'(ex_valid_o), 64'd0);
    check_eq("t3_count1", 64'(stall_count), 64'd1);
    rf_rdata1 = 21;
    step();
    check_eq("t3_bubble2", 64'(ex_valid_o), 64'd0);
    check_eq("t3_count2", 64'(stall_count), 64'd2);
    load_stall = 1'b0; rf_rdata1 = 31; rf_rdata2 = 32;
    expect_issue(32'h10C, mk_r(8, 5, 6), 31, 32);
    step();
    check_eq("t3_issued", 64'(ex_valid_o), 64'd1);
    check_eq("t3_next_held_rs1", 64'(de_rs1), 64'd10);

    // Backpressure
    rf_rdata1 = 32'h40; rf_rdata2 = 32'h41;
    expect_issue(32'h110, mk_r(9, 10, 11), 32'h40, 32'h41);
    fe_insn = mk_r(12, 13, 14); fe_pc = 32'h114;
    step();
    expect_issue(32'h114, mk_r(12, 13, 14), 32'h50, 32'h51);
    fe_insn = mk_r(15, 16, 17); fe_pc = 32'h118;
    ex_ready = 1'b0; rf_rdata1 = 32'h50; rf_rdata2 = 32'h51;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_fe_ready_bp", 64'(fe_ready), 64'd0);
      step();
      check_eq("t4_ex_valid_hold", 64'(ex_valid_o), 64'd1);
      check_eq("t4_ex_pc_hold", 64'(ex_pc), 64'h110);
      check_eq("t4_ex_op1_hold", 64'(ex_op1), 64'h40);
    end
    ex_ready = 1'b1;
    step();
    fe_valid = 1'b0;
    check_eq("t4_resume_pc", 64'(ex_pc), 64'h114);

    // Flush beats everything: I6 in execute and I7 in decode are killed
    void'(exp_q.pop_back());
    flush = 1'b1; load_stall = 1'b1;
    fe_valid = 1'b1; fe_insn = mk_r(18, 19, 20); fe_pc = 32'h11C;
    step();
    flush = 1'b0; load_stall = 1'b0; fe_valid = 1'b0;
    check_eq("t5_ex_valid", 64'(ex_valid_o), 64'd0);
    check_eq("t5_fe_ready", 64'(fe_ready), 64'd1);
    check_eq("t5_stall_count", 64'(stall_count), 64'd2);
    check_eq("t5_ex_pc_kept", 64'(ex_pc), 64'h114);
    step(); step();
    check_eq("t5_dropped", 64'(ex_valid_o), 64'd0);

    // Reset mid-stall
    fe_valid = 1'b1; fe_insn = mk_r(21, 22, 23); fe_pc = 32'h120;
    step();
    fe_valid = 1'b0; load_stall = 1'b1;
    step(); step(); step();
    check_eq("t6_count5", 64'(stall_count), 64'd5);
    reset = 1'b1;
    step();
    reset = 1'b0; load_stall = 1'b0;
    #1;
    check_eq("t6_stall_count", 64'(stall_count), 64'd0);
    check_eq("t6_ex_valid", 64'(ex_valid_o), 64'd0);
    check_eq("t6_ex_insn", 64'(ex_insn), 64'd0);
    check_eq("t6_de_rs1", 64'(de_rs1), 64'd0);
    check_eq("t6_fe_ready", 64'(fe_ready), 64'd1);

    // Post-reset issue, then a long stall to wrap the narrow counter
    fe_valid = 1'b1; fe_insn = mk_r(1, 2, 3); fe_pc = 32'h200;
    rf_rdata1 = 1; rf_rdata2 = 2;
    expect_issue(32'h200, mk_r(1, 2, 3), 1, 2);
    step();
    fe_insn = mk_r(4, 5, 6); fe_pc = 32'h204;
    step();
    fe_valid = 1'b0; load_stall = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_eq("wrap_wide", 64'(stall_count), 64'd10);
    check_eq("wrap_narrow", 64'(n_stall_count), 64'd2);
    load_stall = 1'b0; rf_rdata1 = 32'h77; rf_rdata2 = 32'h88;
    expect_issue(32'h204, mk_r(4, 5, 6), 32'h77, 32'h88);
    step(); step(); step();
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
